// File: rtl/rv32_fetch_pkg.sv
// Shared constants and types for the RV32 instruction fetch stage.
package rv32_fetch_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    NONE         = 2'd0,
    MISALIGNED   = 2'd1,
    OUT_OF_RANGE = 2'd2
  } fault_cause_e;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register, next-PC mux and target/fetch address checks.
module fetch_pc_gen
  import rv32_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  pc_sel_e      i_sel,
  input  logic         i_redirect_valid,
  input  logic [31:0]  i_redirect_pc,
  output logic [31:0]  o_pc,
  output logic [31:0]  o_pc_plus4,
  output fault_cause_e o_fault_cause
);

  // One past the last valid byte address; 33 bits so a 4 GiB memory still fits.
  localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

  logic [31:0] r_pc;
  logic [31:0] w_pc_next;

  // Sequential add wraps modulo 2^32 by construction.
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc + 32'd4;

  // Next-PC selection: hold, sequential step, or redirect target.
  always_comb begin
    // NOTE: default assignment first so every path writes w_pc_next and no latch is inferred.
    w_pc_next = r_pc;
    case (i_sel)
      PC_INC:      w_pc_next = o_pc_plus4;
      PC_REDIRECT: w_pc_next = i_redirect_pc;
      default:     w_pc_next = r_pc;
    endcase
  end

  // Classify the fault this cycle would raise; redirect target wins over fetch address.
  always_comb begin
    o_fault_cause = NONE;
    if (i_redirect_valid) begin
      if (i_redirect_pc[1:0] != 2'b00) o_fault_cause = MISALIGNED;
    end else if ({1'b0, r_pc} >= PC_LIMIT) begin
      o_fault_cause = OUT_OF_RANGE;
    end
  end

  // PC register with asynchronous reset to the boot address.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (!rst) r_pc <= RESET_PC;
    else      r_pc <= w_pc_next;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives instruction memory, fills IF/ID, handles redirect/stall/halt.
module instr_fetch_unit
  import rv32_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  fetch_state_e r_state;
  if_id_t       r_if_id;
  logic         r_id_valid;
  logic         r_halted;
  logic         r_fault;
  logic [31:0]  r_fetch_count;

  logic [31:0]  w_pc;
  logic [31:0]  w_pc_plus4;
  fault_cause_e w_fault_cause;
  pc_sel_e      w_pc_sel;
  logic         w_advance;
  logic         w_accept;
  logic         w_redirect_ok;
  logic         w_fault_take;
  logic         w_capture;

  fetch_pc_gen #(
    .RESET_PC   (RESET_PC),
    .IMEM_WORDS (IMEM_WORDS)
  ) u_pc_gen (
    .clk              (clk),
    .rst              (rst),
    .i_sel            (w_pc_sel),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_pc             (w_pc),
    .o_pc_plus4       (w_pc_plus4),
    .o_fault_cause    (w_fault_cause)
  );

  assign imem_addr   = w_pc;
  assign id_valid    = r_id_valid;
  assign id_instr    = r_if_id.instr;
  assign id_pc       = r_if_id.pc;
  assign id_pc_plus4 = r_if_id.pc_plus4;
  assign halted      = r_halted;
  assign fault       = r_fault;
  assign fetch_count = r_fetch_count;

  // Decide this cycle's action; redirect outranks advance, faults outrank both.
  always_comb begin
    w_advance     = !r_id_valid || id_ready;
    w_accept      = r_id_valid && id_ready;
    w_redirect_ok = (r_state == RUN) && redirect_valid && (w_fault_cause != MISALIGNED);
    w_fault_take  = (r_state == RUN) &&
                    ((redirect_valid && (w_fault_cause == MISALIGNED)) ||
                     (!redirect_valid && w_advance && (w_fault_cause == OUT_OF_RANGE)));
    w_capture     = (r_state == RUN) && !redirect_valid && w_advance &&
                    (w_fault_cause != OUT_OF_RANGE);
    if (w_redirect_ok)  w_pc_sel = PC_REDIRECT;
    else if (w_capture) w_pc_sel = PC_INC;
    else                w_pc_sel = PC_HOLD;
  end

  // FSM, IF/ID register, sticky status flags and accept counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= BOOT;
      r_if_id       <= '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0};
      r_id_valid    <= 1'b0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
      r_fetch_count <= 32'h0;
    end else begin
      if (w_accept) r_fetch_count <= r_fetch_count + 32'd1;
      case (r_state)
        BOOT: r_state <= RUN;
        RUN: begin
          if (w_fault_take) begin
            r_id_valid <= 1'b0;
            r_fault    <= 1'b1;
            r_halted   <= 1'b1;
            r_state    <= HALT;
          end else if (w_redirect_ok) begin
            r_id_valid <= 1'b0;
          end else if (w_capture) begin
            r_if_id    <= '{instr: imem_rdata, pc: w_pc, pc_plus4: w_pc_plus4};
            r_id_valid <= 1'b1;
            if (imem_rdata == EBREAK_INSTR) begin
              r_halted <= 1'b1;
              r_state  <= HALT;
            end
          end
        end
        HALT: begin
          if (w_accept) r_id_valid <= 1'b0;
        end
        default: r_state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;
  logic        ebreak_en;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Instruction memory model: address-tagged words, optional EBREAK at 0x20.
  assign imem_rdata = (ebreak_en && imem_addr == 32'h20) ? EBREAK : {16'hC0DE, imem_addr[15:0]};

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (1024)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .halted         (halted),
    .fault          (fault),
    .fetch_count    (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Step on falling edges until the fetch address matches; bounded.
  task automatic wait_for_addr(input logic [31:0] addr, input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_addr == addr) break;
    end
    check(tag, imem_addr, addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1; ebreak_en = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_valid",  {31'h0, id_valid}, 32'h0);
    check("rst_instr",  id_instr, NOP);
    check("rst_pc",     id_pc, 32'h0);
    check("rst_pc4",    id_pc_plus4, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_fault",  {31'h0, fault}, 32'h0);
    check("rst_count",  fetch_count, 32'h0);
    check("rst_addr",   imem_addr, 32'h0);

    // 1: straight-line fetch
    rst = 1'b1;
    @(negedge clk);
    check("boot_valid", {31'h0, id_valid}, 32'h0);
    check("boot_addr",  imem_addr, 32'h0);
    @(negedge clk);
    check("f0_valid", {31'h0, id_valid}, 32'h1);
    check("f0_pc",    id_pc, 32'h0);
    check("f0_instr", id_instr, 32'hC0DE_0000);
    check("f0_pc4",   id_pc_plus4, 32'h4);
    check("f0_count", fetch_count, 32'h0);
    @(negedge clk);
    check("f4_pc",    id_pc, 32'h4);
    check("f4_count", fetch_count, 32'h1);
    @(negedge clk);
    check("f8_pc",    id_pc, 32'h8);
    check("f8_count", fetch_count, 32'h2);
    check("f8_addr",  imem_addr, 32'hC);

    // 2: decode stall for three cycles
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_pc",    id_pc, 32'h8);
      check("stall_instr", id_instr, 32'hC0DE_0008);
      check("stall_addr",  imem_addr, 32'hC);
      check("stall_count", fetch_count, 32'h2);
    end
    id_ready = 1'b1;
    @(negedge clk);
    check("rel_pc",    id_pc, 32'hC);
    check("rel_count", fetch_count, 32'h3);

    // 3: redirect during a stall
    check("pre_redir_addr", imem_addr, 32'h10);
    id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0; id_ready = 1'b1;
    check("bubble_valid", {31'h0, id_valid}, 32'h0);
    check("bubble_addr",  imem_addr, 32'h40);
    check("bubble_count", fetch_count, 32'h3);
    @(negedge clk);
    check("tgt_valid", {31'h0, id_valid}, 32'h1);
    check("tgt_pc",    id_pc, 32'h40);
    check("tgt_pc4",   id_pc_plus4, 32'h44);
    check("tgt_instr", id_instr, 32'hC0DE_0040);

    // 4: misaligned redirect with simultaneous accept
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    @(negedge clk);
    redirect_pc = 32'h80;
    check("mis_fault",  {31'h0, fault}, 32'h1);
    check("mis_halted", {31'h0, halted}, 32'h1);
    check("mis_valid",  {31'h0, id_valid}, 32'h0);
    check("mis_addr",   imem_addr, 32'h44);
    check("mis_count",  fetch_count, 32'h4);
    @(negedge clk);
    redirect_valid = 1'b0;
    check("halt_redir_addr",  imem_addr, 32'h44);
    check("halt_redir_valid", {31'h0, id_valid}, 32'h0);

    // 5: EBREAK halt
    rst = 1'b0; ebreak_en = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    wait_for_addr(32'h24, "ebk_reach");
    check("ebk_valid",  {31'h0, id_valid}, 32'h1);
    check("ebk_pc",     id_pc, 32'h20);
    check("ebk_instr",  id_instr, EBREAK);
    check("ebk_halted", {31'h0, halted}, 32'h1);
    check("ebk_fault",  {31'h0, fault}, 32'h0);
    check("ebk_count",  fetch_count, 32'h8);
    id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("ebk_hold_valid", {31'h0, id_valid}, 32'h1);
      check("ebk_hold_pc",    id_pc, 32'h20);
      check("ebk_hold_addr",  imem_addr, 32'h24);
    end
    id_ready = 1'b1;
    @(negedge clk);
    check("ebk_drain_valid", {31'h0, id_valid}, 32'h0);
    check("ebk_drain_count", fetch_count, 32'h9);
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("ebk_frz_valid", {31'h0, id_valid}, 32'h0);
      check("ebk_frz_addr",  imem_addr, 32'h24);
      check("ebk_frz_count", fetch_count, 32'h9);
    end

    // 6: asynchronous reset mid-stream
    rst = 1'b0; ebreak_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    wait_for_addr(32'h30, "ar_reach");
    check("ar_pre_pc", id_pc, 32'h2C);
    #2 rst = 1'b0;
    #1;
    check("ar_valid",  {31'h0, id_valid}, 32'h0);
    check("ar_instr",  id_instr, NOP);
    check("ar_addr",   imem_addr, 32'h0);
    check("ar_pc",     id_pc, 32'h0);
    check("ar_count",  fetch_count, 32'h0);
    check("ar_halted", {31'h0, halted}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ar_boot_valid", {31'h0, id_valid}, 32'h0);
    @(negedge clk);
    check("ar_f0_valid", {31'h0, id_valid}, 32'h1);
    check("ar_f0_pc",    id_pc, 32'h0);

    // Out-of-range fetch at the IMEM boundary
    redirect_valid = 1'b1; redirect_pc = 32'hFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("oor_bub_valid", {31'h0, id_valid}, 32'h0);
    check("oor_bub_addr",  imem_addr, 32'hFFC);
    @(negedge clk);
    check("oor_last_valid", {31'h0, id_valid}, 32'h1);
    check("oor_last_pc",    id_pc, 32'hFFC);
    check("oor_last_pc4",   id_pc_plus4, 32'h1000);
    check("oor_last_fault", {31'h0, fault}, 32'h0);
    check("oor_last_addr",  imem_addr, 32'h1000);
    @(negedge clk);
    check("oor_fault",  {31'h0, fault}, 32'h1);
    check("oor_halted", {31'h0, halted}, 32'h1);
    check("oor_valid",  {31'h0, id_valid}, 32'h0);
    check("oor_addr",   imem_addr, 32'h1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage sitting directly upstream of the instruction memory. It owns the program counter and drives the instruction memory address. It captures the returned word into an IF/ID pipeline register and hands it to decode over a valid/ready handshake. It handles branch/jump redirects, decode back-pressure, misaligned-target faults and EBREAK halt.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset; must be word-aligned.
IMEM_WORDS, 1024, instruction memory depth in words; used only for the out-of-range flag.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous assert, active-low (0 = reset).
imem_addr  out  32  byte address to instruction memory; equals current PC, combinational from PC register.
imem_rdata  in  32  instruction word from memory, combinational, same cycle as imem_addr.
redirect_valid  in  1  branch/jump taken from execute.
redirect_pc  in  32  redirect target byte address.
id_ready  in  1  decode can accept IF/ID contents this cycle.
id_valid  out  1  IF/ID register holds a valid instruction.
id_instr  out  32  fetched instruction.
id_pc  out  32  PC of id_instr.
id_pc_plus4  out  32  id_pc + 4, mod 2^32.
halted  out  1  sticky: EBREAK fetched or fault taken.
fault  out  1  sticky: misaligned redirect or PC beyond IMEM_WORDS*4.
fetch_count  out  32  number of instructions accepted by decode (id_valid && id_ready).

Behaviour:
- Reset (rst=0, async):
  - pc = RESET_PC, state = BOOT, id_valid = 0.
  - id_instr = 32'h00000013 (NOP), id_pc = 0, id_pc_plus4 = 0.
  - halted = 0, fault = 0, fetch_count = 0.
  - imem_addr = RESET_PC.
- FSM states: BOOT, RUN, HALT.
- BOOT: lasts exactly one cycle after rst deasserts. No capture, id_valid stays 0. Next state is RUN.
- RUN, advance condition = !id_valid || id_ready:
  - advance and no redirect: IF/ID <= {imem_rdata, pc, pc+4}, id_valid <= 1, pc <= pc+4.
  - not advancing (id_valid && !id_ready): pc and IF/ID hold, and imem_addr stays stable.
- Redirect, highest priority in RUN; applies even during a stall:
  - pc <= redirect_pc and id_valid <= 0 (bubble). The word at the old pc is discarded.
  - The first instruction from the target is valid 1 cycle after the redirect cycle. Redirect penalty is 1 bubble.
  - Simultaneous redirect and id_ready=1 with id_valid=1: the current IF/ID is consumed this cycle and fetch_count increments. The next IF/ID is the bubble.
- Misaligned redirect (redirect_pc[1:0] != 0):
  - pc is not updated, id_valid <= 0.
  - fault <= 1, halted <= 1, state <= HALT.
- Out-of-range fetch: if pc >= IMEM_WORDS*4 when advancing, take the same fault path instead of capturing.
- EBREAK: if the captured word equals 32'h00100073, it is latched with id_valid=1 as normal. state <= HALT and halted <= 1 on the same edge.
- HALT:
  - pc frozen, no further capture, and redirect_valid is ignored.
  - A pending IF/ID entry stays until decode accepts it, then id_valid <= 0.
  - Exit only via reset.
- PC wrap: 32'hFFFFFFFC + 4 = 32'h00000000 with no error. The out-of-range check normally fires first.
- fetch_count: increments on each id_valid && id_ready edge and wraps mod 2^32.
- Reset mid-operation: all state clears immediately and asynchronously, and an in-flight IF/ID entry is lost. Fetch restarts from RESET_PC after BOOT.

Decomposition:
- Package rv32_fetch_pkg:
  - Constants: NOP_INSTR = 32'h00000013, EBREAK_INSTR = 32'h00100073.
  - FSM state typedef {BOOT, RUN, HALT}, 2-bit encoding.
  - Fault-cause enum {NONE, MISALIGNED, OUT_OF_RANGE}.
- Sub-module fetch_pc_gen: PC register, next-PC mux (hold / pc+4 / redirect) and the alignment/range checks.
- The IF/ID register, FSM and counter stay in instr_fetch_unit.

Test Plan:
1. Reset then straight-line code, imem returning addr-derived words, id_ready=1 -> first id_valid 2 cycles after rst release with id_pc=0x0. Then id_pc=0x4, 0x8, 0xC on consecutive cycles; fetch_count=3 after three accepts.
2. id_ready=0 for 3 cycles with IF/ID holding pc=0x8 -> id_instr, id_pc and imem_addr=0xC stable for 3 cycles; no count increment. On release, 0xC is delivered next.
3. Redirect to 0x40 while id_ready=0 at pc=0x10 -> next cycle id_valid=0. The cycle after, id_pc=0x40 and id_pc_plus4=0x44; the word at 0x10 is never delivered.
4. Redirect to 0x42 -> fault=1, halted=1, id_valid=0, pc stays at 0x42's predecessor. A later redirect to 0x80 is ignored.
5. imem returns 32'h00100073 at pc=0x20 -> delivered with id_valid=1, halted=1. After it is accepted, id_valid=0 forever and imem_addr frozen at 0x24.
6. Assert rst mid-stream at pc=0x30 (asynchronously, between edges) -> outputs clear immediately: id_valid=0, id_instr=0x00000013, imem_addr=RESET_PC. Fetch resumes from RESET_PC after BOOT.
